// File: rtl/bloom_filter_ctrl.sv
// Bloom-filter sequencer: shares one hash unit between insert and query
// requesters, owns the bit array and keeps saturating statistics.

module hash_function #(
  parameter int DATA_W = 56,
  parameter int IDX_W  = 6
) (
  input  logic [DATA_W-1:0] i_key,
  output logic [IDX_W-1:0]  o_i1,
  output logic [IDX_W-1:0]  o_i2,
  output logic [IDX_W-1:0]  o_i3
);

  localparam int NCH   = (DATA_W + IDX_W - 1) / IDX_W;
  localparam int PAD_W = NCH * IDX_W;
  localparam int ROT   = DATA_W / 2;

  logic [PAD_W-1:0] w_pad;
  logic [PAD_W-1:0] w_rot;
  logic [IDX_W-1:0] w_x1;
  logic [IDX_W-1:0] w_x2;
  logic [IDX_W-1:0] w_s3;

  assign w_pad = PAD_W'(i_key);
  assign w_rot = PAD_W'({i_key[ROT-1:0], i_key[DATA_W-1:ROT]});

  // i1: xor-fold, i2: xor-fold of half-rotated key, i3: additive fold
  always_comb begin
    w_x1 = '0;
    w_x2 = '0;
    w_s3 = '0;
    for (int c = 0; c < NCH; c++) begin
      w_x1 = w_x1 ^ w_pad[c*IDX_W +: IDX_W];
      w_x2 = w_x2 ^ w_rot[c*IDX_W +: IDX_W];
      w_s3 = w_s3 + w_pad[c*IDX_W +: IDX_W];
    end
  end

  assign o_i1 = w_x1;
  assign o_i2 = w_x2;
  assign o_i3 = w_s3;

endmodule

module bloom_filter_ctrl #(
  parameter int DATA_W  = 56,
  parameter int ARRAY_W = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_req,
  output logic               clr_ack,
  input  logic               ins_valid,
  output logic               ins_ready,
  input  logic [DATA_W-1:0]  ins_data,
  input  logic               qry_valid,
  output logic               qry_ready,
  input  logic [DATA_W-1:0]  qry_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_match,
  output logic [ARRAY_W-1:0] bloom_array,
  output logic               busy,
  output logic [CNT_W-1:0]   ins_count,
  output logic [CNT_W-1:0]   qry_count,
  output logic [CNT_W-1:0]   hit_count
);

  localparam int IDX_W = $clog2(ARRAY_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_INSERT,
    S_QUERY,
    S_RESULT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0]  r_key;
  logic [ARRAY_W-1:0] r_array;
  logic [CNT_W-1:0]   r_ins_cnt;
  logic [CNT_W-1:0]   r_qry_cnt;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic               r_match;
  logic               r_last_qry;

  logic               w_idle;
  logic               w_gnt_ins;
  logic               w_gnt_qry;
  logic               w_ins_hs;
  logic               w_qry_hs;
  logic [IDX_W-1:0]   w_i1;
  logic [IDX_W-1:0]   w_i2;
  logic [IDX_W-1:0]   w_i3;
  logic [ARRAY_W-1:0] w_set;
  logic               w_hit;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  hash_function #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_hash (
    .i_key(r_key),
    .o_i1 (w_i1),
    .o_i2 (w_i2),
    .o_i3 (w_i3)
  );

  assign w_idle = (r_state == S_IDLE);

  // On a tie the requester not served last wins
  assign w_gnt_ins = ins_valid & (~qry_valid | r_last_qry);
  assign w_gnt_qry = qry_valid & (~ins_valid | ~r_last_qry);

  assign w_ins_hs = ins_valid & ins_ready;
  assign w_qry_hs = qry_valid & qry_ready;

  always_comb begin
    w_set       = '0;
    w_set[w_i1] = 1'b1;
    w_set[w_i2] = 1'b1;
    w_set[w_i3] = 1'b1;
  end

  assign w_hit = r_array[w_i1] & r_array[w_i2] & r_array[w_i3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_next = S_CLEAR;
        end else if (w_ins_hs) begin
          w_next = S_INSERT;
        end else if (w_qry_hs) begin
          w_next = S_QUERY;
        end
      end
      S_CLEAR:  w_next = S_IDLE;
      S_INSERT: w_next = S_IDLE;
      S_QUERY:  w_next = S_RESULT;
      S_RESULT: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    clr_ack   = 1'b0;
    ins_ready = 1'b0;
    qry_ready = 1'b0;
    res_valid = 1'b0;
    busy      = ~w_idle;
    unique case (r_state)
      S_IDLE: begin
        ins_ready = ~clr_req & w_gnt_ins;
        qry_ready = ~clr_req & w_gnt_qry;
      end
      S_CLEAR:  clr_ack   = 1'b1;
      S_RESULT: res_valid = 1'b1;
      default: ;
    endcase
    res_match = res_valid & r_match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key      <= '0;
      r_array    <= '0;
      r_ins_cnt  <= '0;
      r_qry_cnt  <= '0;
      r_hit_cnt  <= '0;
      r_match    <= 1'b0;
      r_last_qry <= 1'b1;
    end else begin
      if (w_ins_hs) begin
        r_key      <= ins_data;
        r_last_qry <= 1'b0;
      end else if (w_qry_hs) begin
        r_key      <= qry_data;
        r_last_qry <= 1'b1;
      end
      unique case (r_state)
        S_CLEAR: begin
          r_array   <= '0;
          r_ins_cnt <= '0;
          r_qry_cnt <= '0;
          r_hit_cnt <= '0;
        end
        S_INSERT: begin
          r_array   <= r_array | w_set;
          r_ins_cnt <= sat_inc(r_ins_cnt);
        end
        S_QUERY: begin
          r_match   <= w_hit;
          r_qry_cnt <= sat_inc(r_qry_cnt);
          if (w_hit) begin
            r_hit_cnt <= sat_inc(r_hit_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  assign bloom_array = r_array;
  assign ins_count   = r_ins_cnt;
  assign qry_count   = r_qry_cnt;
  assign hit_count   = r_hit_cnt;

endmodule

// File: tb/tb_bloom_filter_ctrl.sv
// Directed bench for bloom_filter_ctrl with a transaction-level
// reference model checked against the DUT every cycle.

module tb_bloom_filter_ctrl;

  localparam int DATA_W  = 56;
  localparam int ARRAY_W = 64;
  localparam int CNT_W   = 2;
  localparam int CMAX    = 3;

  logic               clk;
  logic               rst;
  logic               clr_req;
  logic               clr_ack;
  logic               ins_valid;
  logic               ins_ready;
  logic [DATA_W-1:0]  ins_data;
  logic               qry_valid;
  logic               qry_ready;
  logic [DATA_W-1:0]  qry_data;
  logic               res_valid;
  logic               res_ready;
  logic               res_match;
  logic [ARRAY_W-1:0] bloom_array;
  logic               busy;
  logic [CNT_W-1:0]   ins_count;
  logic [CNT_W-1:0]   qry_count;
  logic [CNT_W-1:0]   hit_count;

  bloom_filter_ctrl #(
    .DATA_W (DATA_W),
    .ARRAY_W(ARRAY_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .clr_ack    (clr_ack),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_data   (ins_data),
    .qry_valid  (qry_valid),
    .qry_ready  (qry_ready),
    .qry_data   (qry_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_match  (res_match),
    .bloom_array(bloom_array),
    .busy       (busy),
    .ins_count  (ins_count),
    .qry_count  (qry_count),
    .hit_count  (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Hash reference: ten 6-bit chunks of the zero-padded key
  function automatic void bhash(input logic [55:0] k,
                                output int a, output int b,
                                output int c);
    longint unsigned v;
    longint unsigned r;
    v = longint'(k);
    r = (v % 64'h1000_0000) * 64'h1000_0000 + v / 64'h1000_0000;
    a = 0;
    b = 0;
    c = 0;
    for (int j = 0; j < 10; j++) begin
      a = a ^ int'((v >> (6 * j)) % 64);
      b = b ^ int'((r >> (6 * j)) % 64);
      c = (c + int'((v >> (6 * j)) % 64)) % 64;
    end
  endfunction

  function automatic logic [63:0] kmask(input logic [55:0] k);
    int a, b, c;
    bhash(k, a, b, c);
    return (64'd1 << a) | (64'd1 << b) | (64'd1 << c);
  endfunction

  // Reference model state
  logic [63:0] m_array = '0;
  int          m_ins = 0;
  int          m_qry = 0;
  int          m_hit = 0;
  logic        m_rv = 1'b0;
  logic        m_match = 1'b0;
  int          cyc = 0;

  typedef struct {
    int          due;
    int          kind;
    logic [55:0] key;
  } ev_t;
  ev_t evq[$];

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      evq.delete();
      m_array = '0;
      m_ins   = 0;
      m_qry   = 0;
      m_hit   = 0;
      m_rv    = 1'b0;
      m_match = 1'b0;
    end else begin
      while (evq.size() > 0 && evq[0].due <= cyc) begin
        ev_t e;
        e = evq.pop_front();
        case (e.kind)
          0: begin
            m_array = m_array | kmask(e.key);
            m_ins   = sat(m_ins);
          end
          1: begin
            m_match = ((m_array & kmask(e.key)) == kmask(e.key));
            m_qry   = sat(m_qry);
            if (m_match) m_hit = sat(m_hit);
            m_rv = 1'b1;
          end
          2: m_rv = 1'b0;
          default: begin
            m_array = '0;
            m_ins   = 0;
            m_qry   = 0;
            m_hit   = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle compare, then log this cycle's accepted transactions
  always @(negedge clk) begin
    chk("mon_array", bloom_array, m_array);
    chk("mon_ins_cnt", 64'(ins_count), 64'(m_ins));
    chk("mon_qry_cnt", 64'(qry_count), 64'(m_qry));
    chk("mon_hit_cnt", 64'(hit_count), 64'(m_hit));
    chk("mon_res_valid", 64'(res_valid), 64'(m_rv));
    chk("mon_res_match", 64'(res_match), 64'(m_rv & m_match));
    if (!rst) begin
      if (ins_valid && ins_ready) evq.push_back('{cyc + 2, 0, ins_data});
      if (qry_valid && qry_ready) evq.push_back('{cyc + 2, 1, qry_data});
      if (m_rv && res_ready) evq.push_back('{cyc + 1, 2, 56'd0});
      if (clr_ack) evq.push_back('{cyc + 1, 3, 56'd0});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    ins_valid = 1'b0;
    qry_valid = 1'b0;
    clr_req   = 1'b0;
    res_ready = 1'b1;
    rst       = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_ins(input logic [55:0] k);
    int t;
    t = 0;
    ins_valid = 1'b1;
    ins_data  = k;
    @(negedge clk);
    while (!ins_ready && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("ins_hs_timeout", 64'(t < 20), 64'd1);
    step();
    ins_valid = 1'b0;
    step();
    step();
  endtask

  logic last_match;

  task automatic do_qry(input logic [55:0] k, input int hold);
    int   t;
    logic m0;
    t = 0;
    qry_valid = 1'b1;
    qry_data  = k;
    @(negedge clk);
    while (!qry_ready && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("qry_hs_timeout", 64'(t < 20), 64'd1);
    step();
    qry_valid = 1'b0;
    if (hold > 0) res_ready = 1'b0;
    @(negedge clk);
    chk("qry_lat1_valid", 64'(res_valid), 64'd0);
    chk("qry_lat1_busy", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    chk("qry_lat2_valid", 64'(res_valid), 64'd1);
    last_match = res_match;
    m0 = res_match;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_match", 64'(res_match), 64'(m0));
      chk("hold_qry_ready", 64'(qry_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      step();
      @(negedge clk);
    end
    step();
    if (hold > 0) begin
      res_ready = 1'b1;
      step();
    end
    @(negedge clk);
    chk("rel_busy", 64'(busy), 64'd0);
    chk("rel_valid", 64'(res_valid), 64'd0);
    step();
  endtask

  localparam logic [55:0] K  = 56'h00_1122_3344_5566;
  localparam logic [55:0] K2 = 56'hA5_0F3C_9D21_7B40;
  localparam logic [55:0] K3 = 56'h13_5792_4680_ACE1;
  localparam logic [55:0] K4 = 56'h5A_5A5A_0000_FFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a, b, c;
    int ord[4];
    int ng, ni, nq, t, pop;
    logic gi, gq;
    logic [55:0] ia[2];
    logic [55:0] qa[2];
    logic [63:0] am;

    rst       = 1'b1;
    clr_req   = 1'b0;
    ins_valid = 1'b0;
    ins_data  = '0;
    qry_valid = 1'b0;
    qry_data  = '0;
    res_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Hand-computed hash values pin the model
    bhash(56'h1, a, b, c);
    chk("hash1_i1", 64'(a), 64'd1);
    chk("hash1_i2", 64'(b), 64'd16);
    chk("hash1_i3", 64'(c), 64'd1);
    bhash(56'h3F, a, b, c);
    chk("hash3f_i1", 64'(a), 64'd63);
    chk("hash3f_i2", 64'(b), 64'd63);
    chk("hash3f_i3", 64'(c), 64'd63);

    @(negedge clk);
    chk("rst_array", bloom_array, 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_clr_ack", 64'(clr_ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ins_cnt", 64'(ins_count), 64'd0);
    step();

    do_qry(56'h0, 0);
    chk("q0_match", 64'(last_match), 64'd0);
    chk("q0_qry_cnt", 64'(qry_count), 64'd1);
    chk("q0_hit_cnt", 64'(hit_count), 64'd0);
    chk("q0_array", bloom_array, 64'd0);

    do_ins(56'h1);
    chk("ins1_array", bloom_array, 64'h0000_0000_0001_0002);
    do_ins(56'h3F);
    chk("ins3f_array", bloom_array, 64'h8000_0000_0001_0002);
    chk("ins3f_cnt", 64'(ins_count), 64'd2);

    do_reset();
    do_ins(K);
    chk("insK_cnt", 64'(ins_count), 64'd1);
    chk("insK_array", bloom_array, kmask(K));
    pop = $countones(bloom_array);
    chk("insK_pop", 64'(pop >= 1 && pop <= 3), 64'd1);
    do_qry(K, 0);
    chk("qK_match", 64'(last_match), 64'd1);
    chk("qK_hit_cnt", 64'(hit_count), 64'd1);

    // Alternating grants with both requesters held valid
    do_reset();
    ia[0] = K2; ia[1] = K3;
    qa[0] = K2; qa[1] = K4;
    ng = 0; ni = 0; nq = 0; t = 0;
    ins_valid = 1'b1; ins_data = ia[0];
    qry_valid = 1'b1; qry_data = qa[0];
    while (ng < 4 && t < 60) begin
      @(negedge clk);
      t++;
      gi = ins_valid && ins_ready;
      gq = qry_valid && qry_ready;
      if (gi && gq) chk("alt_double_grant", 64'd1, 64'd0);
      if (gi && ng < 4) begin ord[ng] = 0; ng++; end
      if (gq && ng < 4) begin ord[ng] = 1; ng++; end
      step();
      if (gi) begin
        ni++;
        if (ni >= 2) ins_valid = 1'b0;
        else ins_data = ia[ni];
      end
      if (gq) begin
        nq++;
        if (nq >= 2) qry_valid = 1'b0;
        else qry_data = qa[nq];
      end
    end
    chk("alt_timeout", 64'(ng), 64'd4);
    chk("alt_g0", 64'(ord[0]), 64'd0);
    chk("alt_g1", 64'(ord[1]), 64'd1);
    chk("alt_g2", 64'(ord[2]), 64'd0);
    chk("alt_g3", 64'(ord[3]), 64'd1);
    repeat (4) step();
    chk("alt_ins_cnt", 64'(ins_count), 64'd2);
    chk("alt_qry_cnt", 64'(qry_count), 64'd2);

    // Clear beats a simultaneous insert
    clr_req   = 1'b1;
    ins_valid = 1'b1;
    ins_data  = K;
    @(negedge clk);
    chk("clr_ins_ready0", 64'(ins_ready), 64'd0);
    chk("clr_ack_pre", 64'(clr_ack), 64'd0);
    step();
    @(negedge clk);
    chk("clr_ack_pulse", 64'(clr_ack), 64'd1);
    chk("clr_ins_ready1", 64'(ins_ready), 64'd0);
    chk("clr_busy", 64'(busy), 64'd1);
    step();
    clr_req = 1'b0;
    @(negedge clk);
    chk("clr_then_ins_ready", 64'(ins_ready), 64'd1);
    step();
    ins_valid = 1'b0;
    step();
    step();
    chk("clr_ins_array", bloom_array, kmask(K));
    chk("clr_ins_cnt", 64'(ins_count), 64'd1);

    // Held clear repeats with one idle cycle between
    clr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clr_repeat", 64'(clr_ack), 64'(i % 2));
      step();
    end
    clr_req = 1'b0;
    step();
    am = bloom_array;
    chk("clr_repeat_array", am, 64'd0);

    do_ins(K);
    do_qry(K, 5);
    chk("hold_last_match", 64'(last_match), 64'd1);

    do_reset();
    do_ins(K);
    do_ins(K2);
    do_ins(K3);
    do_ins(K4);
    do_ins(56'h1);
    chk("sat_ins_cnt", 64'(ins_count), 64'd3);

    // Reset while a result is pending
    t = 0;
    qry_valid = 1'b1;
    qry_data  = K;
    res_ready = 1'b0;
    @(negedge clk);
    while (!qry_ready && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("rr_hs_timeout", 64'(t < 20), 64'd1);
    step();
    qry_valid = 1'b0;
    step();
    @(negedge clk);
    chk("rr_valid_pre", 64'(res_valid), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr_valid", 64'(res_valid), 64'd0);
    chk("rr_array", bloom_array, 64'd0);
    chk("rr_ins_cnt", 64'(ins_count), 64'd0);
    chk("rr_qry_cnt", 64'(qry_count), 64'd0);
    chk("rr_hit_cnt", 64'(hit_count), 64'd0);
    chk("rr_busy", 64'(busy), 64'd0);
    res_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bloom_filter_ctrl.md
Name: bloom_filter_ctrl

Overview:
Sequencing and arbitration controller for the NIDS Bloom-filter match datapath. It owns the 64-bit Bloom array register and shares a single hash_function instance between two requesters. The insert requester programs signatures into the array. The query requester tests 56-bit packet windows against it. The block also handles a clear command and maintains saturating statistics counters.

Parameters:
DATA_W, 56, key width; fixed by hash_function input width.
ARRAY_W, 64, Bloom array width; hash indices are log2(ARRAY_W)=6 bits.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
clr_req  in  1  level request to zero the array and counters.
clr_ack  out  1  one-cycle pulse in the cycle the clear is performed.
ins_valid  in  1  insert request valid.
ins_ready  out  1  insert accepted when ins_valid & ins_ready.
ins_data  in  DATA_W  signature to insert.
qry_valid  in  1  query request valid.
qry_ready  out  1  query accepted when qry_valid & qry_ready.
qry_data  in  DATA_W  packet window to test.
res_valid  out  1  query result valid.
res_ready  in  1  result consumer ready.
res_match  out  1  1 when all three hashed bits are set.
bloom_array  out  ARRAY_W  current array contents (registered).
busy  out  1  high whenever the FSM is not in IDLE.
ins_count  out  CNT_W  number of inserts performed; saturating.
qry_count  out  CNT_W  number of queries completed; saturating.
hit_count  out  CNT_W  number of queries with res_match=1; saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE.
  - bloom_array, all counters, res_valid, res_match and clr_ack are 0.
  - Any captured key or pending result is discarded.
  - The last-grant pointer is set to "query", so insert wins the first tie.
- FSM states: IDLE, CLEAR, INSERT, QUERY, RESULT.
- IDLE arbitration, evaluated combinationally each cycle:
  - clr_req has the highest priority. Next state is CLEAR; ins_ready and qry_ready are 0.
  - Otherwise, if only one of ins_valid / qry_valid is high, grant that requester.
  - If both are high, grant the requester not granted last (strict alternation).
  - ins_ready = IDLE & !clr_req & grant_ins; qry_ready = IDLE & !clr_req & grant_qry. Both ready signals are 0 in every other state.
  - On the handshake at edge N, the key is captured into key_r and the FSM moves to INSERT or QUERY. The last-grant pointer is updated.
- CLEAR (1 cycle):
  - bloom_array, ins_count, qry_count and hit_count are set to 0 at the end of the cycle.
  - clr_ack=1 during this cycle.
  - Next state is IDLE.
  - clr_req held high causes a repeat clear, with one IDLE cycle between clears.
- INSERT (1 cycle):
  - hash_function(key_r) gives i1, i2, i3.
  - bloom_array bits i1, i2 and i3 are set (OR) at the edge ending the cycle; duplicate indices are harmless.
  - ins_count is incremented.
  - Next state is IDLE. The update is visible on bloom_array at N+2.
- QUERY (1 cycle):
  - res_match_r = bloom_array[i1] & bloom_array[i2] & bloom_array[i3], using the current array. Every insert accepted earlier is included.
  - qry_count is incremented; hit_count is incremented if the match is 1.
  - Next state is RESULT.
- RESULT:
  - res_valid=1; res_match is held stable.
  - On res_valid & res_ready, res_valid drops next cycle and the FSM returns to IDLE.
  - clr_req arriving while in RESULT waits until the result is consumed.
- Latency and throughput:
  - Query: handshake at N, res_valid asserted at N+2.
  - Peak rates: one insert per 2 cycles; one query per 3 cycles (with res_ready=1).
- Counters stick at 2^CNT_W-1 and never wrap.
- res_match is 0 whenever res_valid is 0.
- busy = (state != IDLE).
- rst asserted mid-operation wins over every other event in the same cycle.

Test Plan:
- Reset, then query 56'h0 with res_ready=1 -> res_valid at handshake+2, res_match=0; bloom_array=0; qry_count=1, hit_count=0.
- Insert K=56'h00_1122_3344_5566, then query K -> res_match=1. bloom_array has 1–3 bits set, matching the hash model's indices. ins_count=1, hit_count=1.
- ins_valid and qry_valid held together with two keys each -> grant order INS, QRY, INS, QRY. No requester gets two consecutive grants while the other is waiting.
- clr_req and ins_valid asserted in the same IDLE cycle -> ins_ready=0 and clr_ack pulses first. The insert is accepted on the next IDLE cycle; the final array holds only that key's bits and ins_count=1.
- Query completes, then res_ready held low for 5 cycles -> res_valid and res_match stay stable, qry_ready=0, busy=1. Releasing res_ready returns the FSM to IDLE on the next cycle.
- CNT_W=2 with 5 inserts -> ins_count saturates at 3. rst asserted during RESULT -> res_valid=0 next cycle, with bloom_array and all counters at 0.
